// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory; `MEM_STARTUP_DELAY_EN adds a power-up hold-off.
// Latency: ack pulses in the cycle after grant edge + 2, so one access completes per 3 clocks under contention.
// Backpressure: req is held until ack; a port is ignored while its own ack is high; requests wait while busy_o is high.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int STARTUP_CYCLES = 48
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req0_i,
  input  logic                  req1_i,
  input  logic                  we0_i,
  input  logic                  we1_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] data0_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  output logic                  ack0_o,
  output logic                  ack1_o,
  output logic [DATA_WIDTH-1:0] data0_o,
  output logic [DATA_WIDTH-1:0] data1_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_write_en_no,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {STARTUP, IDLE, ACCESS, CAPTURE} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   grant_q;
  logic   we_q;
  logic   req0_act, req1_act;
  logic   do_grant, grant_nxt;

`ifdef MEM_STARTUP_DELAY_EN
  localparam int CNT_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  logic [CNT_W-1:0] startup_cnt;
  logic             startup_done;

  assign startup_done = (startup_cnt == CNT_W'(STARTUP_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      startup_cnt <= '0;
    end else if (state == STARTUP && !startup_done) begin
      startup_cnt <= startup_cnt + 1'b1;
    end
  end
`endif

  // A port whose ack is high this cycle is done; its still-high req must not regrant.
  assign req0_act = req0_i && !ack0_o;
  assign req1_act = req1_i && !ack1_o;

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    grant_nxt = grant_q;
    case (state)
      STARTUP: begin
`ifdef MEM_STARTUP_DELAY_EN
        if (startup_done) state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      IDLE: begin
        if (req0_act && req1_act) begin
          do_grant  = 1'b1;
          grant_nxt = ~last_grant;
        end else if (req0_act) begin
          do_grant  = 1'b1;
          grant_nxt = 1'b0;
        end else if (req1_act) begin
          do_grant  = 1'b1;
          grant_nxt = 1'b1;
        end
        if (do_grant) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
`ifdef MEM_STARTUP_DELAY_EN
      state      <= STARTUP;
`else
      state      <= IDLE;
`endif
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      we_q       <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      ack0_o     <= 1'b0;
      ack1_o     <= 1'b0;
      data0_o    <= '0;
      data1_o    <= '0;
    end else begin
      state  <= state_nxt;
      ack0_o <= 1'b0;
      ack1_o <= 1'b0;
      if (do_grant) begin
        grant_q    <= grant_nxt;
        we_q       <= grant_nxt ? we1_i   : we0_i;
        mem_addr_o <= grant_nxt ? addr1_i : addr0_i;
        mem_data_o <= grant_nxt ? data1_i : data0_i;
      end
      if (state == CAPTURE) begin
        last_grant <= grant_q;
        if (grant_q) begin
          ack1_o <= 1'b1;
          if (!we_q) data1_o <= mem_data_i;
        end else begin
          ack0_o <= 1'b1;
          if (!we_q) data0_o <= mem_data_i;
        end
      end
    end
  end

  // Gating with reset_i keeps an aborted write from landing in memory on the reset edge.
  assign mem_write_en_no = !((state == ACCESS) && we_q && !reset_i);
  assign busy_o          = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural one-cycle-latency memory on its memory port.
module tb_mem_arbiter;

  localparam int STARTUP = 48;
`ifdef MEM_STARTUP_DELAY_EN
  localparam int FIRST_LAT = STARTUP + 3;
`else
  localparam int FIRST_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdat0 = '0, wdat1 = '0;
  logic        ack0, ack1;
  logic [15:0] rdat0, rdat1;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdat;
  logic        mem_we_n;
  logic [15:0] mem_rdat = '0;
  logic        busy;

  logic [15:0] mem [0:255];
  logic        init_pend = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .STARTUP_CYCLES(STARTUP)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .data0_i(wdat0), .data1_i(wdat1),
    .ack0_o(ack0), .ack1_o(ack1), .data0_o(rdat0), .data1_o(rdat1),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdat), .mem_write_en_no(mem_we_n),
    .mem_data_i(mem_rdat), .busy_o(busy)
  );

  // Memory contents start as 0xA000 + address.
  always @(posedge clk) begin
    if (init_pend) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
      init_pend <= 1'b0;
    end else begin
      if (!mem_we_n) mem[mem_addr] <= mem_wdat;
      mem_rdat <= mem[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one access and reports cycles to ack (0 if it never came), cycles with write enable low, and double-ack cycles.
  task automatic run_access(input int p, input logic we, input logic [7:0] a, input logic [15:0] d,
                            input int max_cyc, output int lat, output int wen_cyc, output int both);
    if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdat0 = d; end
    else        begin req1 = 1'b1; we1 = we; addr1 = a; wdat1 = d; end
    lat = 0; wen_cyc = 0; both = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk); #1;
      if (!mem_we_n) wen_cyc++;
      if (ack0 && ack1) both++;
      if ((p == 0 && ack0) || (p == 1 && ack1)) begin
        lat = i;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wen, both, n, simul, first_ack, second_ack, busy4, busy5, ack_seen;
    int ack_t[4];
    int ack_p[4];

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ack0", ack0, 0);
    check_eq("rst_ack1", ack1, 0);
    check_eq("rst_data0", rdat0, 0);
    check_eq("rst_data1", rdat1, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_data", mem_wdat, 0);
    check_eq("rst_we_n", mem_we_n, 1);
`ifdef MEM_STARTUP_DELAY_EN
    check_eq("rst_busy", busy, 1);
`else
    check_eq("rst_busy", busy, 0);
`endif
    reset_i = 1'b0;

    // First read of 0x02 straight out of reset (includes hold-off when enabled).
    run_access(0, 1'b0, 8'h02, 16'h0000, FIRST_LAT + 5, lat, wen, both);
    check_eq("rd02_latency", lat, FIRST_LAT);
    check_eq("rd02_we_n_cycles", wen, 0);
    check_eq("rd02_data0", rdat0, 16'hA002);

    run_access(1, 1'b1, 8'hFF, 16'h0055, 10, lat, wen, both);
    check_eq("wrFF_latency", lat, 3);
    check_eq("wrFF_we_n_cycles", wen, 1);
    check_eq("wrFF_data1_unchanged", rdat1, 16'h0000);
    check_eq("wrFF_mem", mem[8'hFF], 16'h0055);

    run_access(1, 1'b0, 8'hFF, 16'h0000, 10, lat, wen, both);
    check_eq("rdFF_latency", lat, 3);
    check_eq("rdFF_we_n_cycles", wen, 0);
    check_eq("rdFF_data1", rdat1, 16'h0055);
    check_eq("rdFF_data0_unchanged", rdat0, 16'hA002);

    // Contention: last grant was port 1, so port 0 wins first and grants alternate.
    n = 0; simul = 0;
    for (int k = 0; k < 4; k++) begin ack_t[k] = -1; ack_p[k] = -1; end
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
    for (int c = 1; c <= 20 && n < 4; c++) begin
      @(posedge clk); #1;
      if (ack0 && ack1) simul++;
      else if (ack0) begin ack_p[n] = 0; ack_t[n] = c; n++; end
      else if (ack1) begin ack_p[n] = 1; ack_t[n] = c; n++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    check_eq("rr_count", n, 4);
    check_eq("rr_simultaneous", simul, 0);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("rr_port%0d", k), ack_p[k], k % 2);
      check_eq($sformatf("rr_time%0d", k), ack_t[k], 3 * (k + 1));
    end
    check_eq("rr_data0", rdat0, 16'hA010);
    check_eq("rr_data1", rdat1, 16'hA020);

    // Port 0 keeps req high through its ack cycle: no grant there, regrant the cycle after.
    first_ack = 0; second_ack = 0; busy4 = -1; busy5 = -1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h03;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 4) busy4 = int'(busy);
      if (c == 5) busy5 = int'(busy);
      if (ack0) begin
        if (first_ack == 0) first_ack = c;
        else begin second_ack = c; break; end
      end
    end
    req0 = 1'b0;
    @(posedge clk); #1;
    check_eq("hold_first_ack", first_ack, 3);
    check_eq("hold_busy_in_ack_cycle", busy4, 0);
    check_eq("hold_busy_regrant", busy5, 1);
    check_eq("hold_second_ack", second_ack, 7);
    check_eq("hold_data0", rdat0, 16'hA003);

    // Reset lands while a write of 0x1234 to 0x01 is in ACCESS.
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h01; wdat0 = 16'h1234;
    @(posedge clk); #1;
    check_eq("abort_in_access", busy, 1);
    check_eq("abort_addr", mem_addr, 8'h01);
    reset_i = 1'b1;
    #1;
    check_eq("abort_we_n_gated", mem_we_n, 1);
    @(posedge clk); #1;
    req0 = 1'b0;
    check_eq("abort_ack0", ack0, 0);
    check_eq("abort_ack1", ack1, 0);
    check_eq("abort_data0", rdat0, 0);
    check_eq("abort_data1", rdat1, 0);
    check_eq("abort_mem_addr", mem_addr, 0);
    check_eq("abort_mem_data", mem_wdat, 0);
    check_eq("abort_we_n", mem_we_n, 1);
    reset_i = 1'b0;
    ack_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ack0 || ack1 || !mem_we_n) ack_seen++;
    end
    check_eq("abort_no_ack_or_write", ack_seen, 0);
    check_eq("abort_mem01", mem[8'h01], 16'hA001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, memory data width.
REQ-003 SHALL have parameter STARTUP_CYCLES, default 48, hold-off length in clocks (3 us at 16 MHz).
REQ-004 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports req0_i/req1_i  input  1  access request from port 0/1, held until ack.
REQ-007 SHALL have ports we0_i/we1_i  input  1  1 = write, 0 = read; stable while request is high.
REQ-008 SHALL have ports addr0_i/addr1_i  input  ADDR_WIDTH  access address.
REQ-009 SHALL have ports data0_i/data1_i  input  DATA_WIDTH  write data.
REQ-010 SHALL have ports ack0_o/ack1_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports data0_o/data1_o  output  DATA_WIDTH  read data, valid while ack is high and held until next read completes on that port.
REQ-012 SHALL have port mem_addr_o  output  ADDR_WIDTH  address to Memory address_i.
REQ-013 SHALL have port mem_data_o  output  DATA_WIDTH  write data to Memory data_i.
REQ-014 SHALL have port mem_write_en_no  output  1  active-low write enable to Memory write_en_ni.
REQ-015 SHALL have port mem_data_i  input  DATA_WIDTH  Memory data_o, one-clock synchronous read latency.
REQ-016 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states STARTUP, IDLE, ACCESS, CAPTURE.
REQ-018 SHALL, in IDLE, treat a port as requesting only when its req is high and its ack_o is low in that cycle.
REQ-019 SHALL, in IDLE with one port requesting, grant it; load mem_addr_o, mem_data_o and the latched we from that port; go to ACCESS.
REQ-020 SHALL, with both ports requesting, grant the port not granted last (round-robin); last_grant resets to 1, so port 0 wins the first tie.
REQ-021 SHALL, in ACCESS, drive mem_write_en_no low only if the latched we is 1 and reset_i is 0 (combinational gate); otherwise high. Next state is CAPTURE.
REQ-022 SHALL, leaving CAPTURE, load data<n>_o from mem_data_i for reads only, assert ack<n>_o for exactly one cycle, update last_grant and go to IDLE.
REQ-023 SHALL give a fixed latency: grant edge k, ack high in the cycle after edge k+2; data0_o/data1_o unchanged on writes.
REQ-024 SHALL allow the other port to be granted in the IDLE cycle where the previous ack is high, giving one access per 3 clocks under contention.
REQ-025 SHALL hold mem_addr_o and mem_data_o stable from grant until the next grant.
REQ-026 SHALL never assert ack0_o and ack1_o in the same cycle.

Reset
REQ-027 SHALL, on reset_i high at a rising edge, set ack0_o=ack1_o=0, data0_o=data1_o=0, mem_addr_o=0, mem_data_o=0, mem_write_en_no=1 and last_grant=1.
REQ-028 SHALL enter STARTUP when MEM_STARTUP_DELAY_EN is defined, otherwise IDLE.
REQ-029 SHALL abort an in-flight access when reset is asserted mid-operation: no ack, and no memory write committed when reset is high during ACCESS.

Configuration
REQ-030 SHALL, with macro MEM_STARTUP_DELAY_EN defined, hold STARTUP for exactly STARTUP_CYCLES clocks after reset, with busy_o=1 and requests ignored, then enter IDLE.
REQ-031 SHALL, without MEM_STARTUP_DELAY_EN, omit STARTUP and its counter; IDLE is entered on the first edge after reset release and busy_o resets to 0.

Verification
REQ-032 SHALL cover: with EN, reset then req0_i=1 read addr 0x02 at cycle 0 -> no grant before cycle 48; ack0_o pulses once; data0_o = mem[0x02].
REQ-033 SHALL cover: without EN, port 1 writes 0x0055 to 0xFF and then reads 0xFF -> mem_write_en_no low exactly one cycle; read returns 0x0055; ack1_o exactly 3 cycles after each grant.
REQ-034 SHALL cover: req0_i and req1_i both held high for 4 accesses -> grants alternate 0,1,0,1; acks are never simultaneous; spacing is 3 cycles.
REQ-035 SHALL cover: reset_i asserted during ACCESS of a write of 0x1234 to 0x01 -> mem_write_en_no stays high; mem[0x01] unchanged; no ack; outputs match REQ-027.
REQ-036 SHALL cover: port 0 keeps req0_i high in its ack cycle with port 1 idle -> regrant of port 0 only on the cycle after ack.
